// File: rtl/score_display_ctrl.sv
// Score/lives owner with a 3-step BCD adder FSM and a frame-stable shadow score.
// Per pixel, selects the active digit slot and emits glyph code, offsets and visibility.
module score_display_ctrl #(
  parameter int unsigned TOP_X      = 16,
  parameter int unsigned TOP_Y      = 8,
  parameter int unsigned DIGIT_W    = 16,
  parameter int unsigned DIGIT_H    = 32,
  parameter int unsigned DIGIT_GAP  = 4,
  parameter int unsigned LIVES_INIT = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [10:0]      pixelX,
  input  logic [10:0]      pixelY,
  input  logic             startOfFrame,
  input  logic             addReq,
  input  logic [1:0][3:0]  addPoints,
  input  logic             loseLife,
  input  logic             resetScore,
  output logic             busy,
  output logic [2:0][3:0]  score,
  output logic [3:0]       digitCode,
  output logic [10:0]      offsetX,
  output logic [10:0]      offsetY,
  output logic             insideRectangle,
  output logic [1:0]       lives,
  output logic             gameOver
);

  localparam int unsigned SLOTS = 3;
  localparam int unsigned PITCH = DIGIT_W + DIGIT_GAP;

  typedef enum logic [1:0] {IDLE, ADD0, ADD1, ADD2} state_t;

  state_t          state, state_d;
  logic [1:0][3:0] pts, pts_d;
  logic            carry, carry_d;
  logic [2:0][3:0] score_d;
  logic            busy_d;
  logic [1:0]      lives_d;
  logic [4:0]      sum;
  logic [2:0][3:0] shadow;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Adder FSM state and datapath registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      pts     <= '0;
      carry   <= 1'b0;
      score   <= '0;
      busy    <= 1'b0;
      lives   <= 2'(LIVES_INIT);
      gameOver <= 1'b0;
    end else begin
      state    <= state_d;
      pts      <= pts_d;
      carry    <= carry_d;
      score    <= score_d;
      busy     <= busy_d;
      lives    <= lives_d;
      gameOver <= (lives_d == 2'd0);
    end
  end

  // One BCD digit per step; resetScore overrides everything
  always_comb begin
    state_d = state;
    pts_d   = pts;
    carry_d = carry;
    score_d = score;
    sum     = '0;
    unique case (state)
      IDLE: begin
        if (addReq) begin
          pts_d[0] = clamp_bcd(addPoints[0]);
          pts_d[1] = clamp_bcd(addPoints[1]);
          carry_d  = 1'b0;
          state_d  = ADD0;
        end
      end
      ADD0: begin
        sum = 5'(score[0]) + 5'(pts[0]);
        if (sum > 5'd9) begin
          score_d[0] = 4'(sum - 5'd10);
          carry_d    = 1'b1;
        end else begin
          score_d[0] = sum[3:0];
          carry_d    = 1'b0;
        end
        state_d = ADD1;
      end
      ADD1: begin
        sum = 5'(score[1]) + 5'(pts[1]) + 5'(carry);
        if (sum > 5'd9) begin
          score_d[1] = 4'(sum - 5'd10);
          carry_d    = 1'b1;
        end else begin
          score_d[1] = sum[3:0];
          carry_d    = 1'b0;
        end
        state_d = ADD2;
      end
      ADD2: begin
        sum = 5'(score[2]) + 5'(carry);
        if (sum > 5'd9) begin
          score_d = 12'h999;
        end else begin
          score_d[2] = sum[3:0];
        end
        carry_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (resetScore) begin
      state_d = IDLE;
      score_d = '0;
      carry_d = 1'b0;
    end

    busy_d = (state_d != IDLE);

    lives_d = lives;
    if (resetScore) begin
      lives_d = 2'(LIVES_INIT);
    end else if (loseLife && (lives != 2'd0)) begin
      lives_d = lives - 2'd1;
    end
  end

  // Shadow only refreshes between adds so a frame never shows a half-updated score
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow <= '0;
    end else if (startOfFrame && (state == IDLE)) begin
      shadow <= score;
    end
  end

  logic        in_y;
  logic        hit;
  logic [1:0]  slot;
  logic [10:0] slot_x;
  logic [3:0]  digit;
  logic        blank;

  // Slot decode for the current pixel
  always_comb begin
    in_y   = (pixelY >= 11'(TOP_Y)) && (pixelY < 11'(TOP_Y + DIGIT_H));
    hit    = 1'b0;
    slot   = '0;
    slot_x = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if ((pixelX >= 11'(TOP_X + k * PITCH)) &&
          (pixelX <  11'(TOP_X + k * PITCH + DIGIT_W))) begin
        hit    = in_y;
        slot   = 2'(k);
        slot_x = 11'(TOP_X + k * PITCH);
      end
    end

    unique case (slot)
      2'd0:    digit = shadow[2];
      2'd1:    digit = shadow[1];
      default: digit = shadow[0];
    endcase

    blank = ((slot == 2'd0) && (shadow[2] == 4'd0)) ||
            ((slot == 2'd1) && (shadow[2] == 4'd0) && (shadow[1] == 4'd0));
  end

  // Registered pixel outputs; digitCode holds outside the slots
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digitCode       <= '0;
      offsetX         <= '0;
      offsetY         <= '0;
      insideRectangle <= 1'b0;
    end else if (hit) begin
      digitCode       <= digit;
      offsetX         <= pixelX - slot_x;
      offsetY         <= pixelY - 11'(TOP_Y);
      insideRectangle <= ~blank;
    end else begin
      offsetX         <= '0;
      offsetY         <= '0;
      insideRectangle <= 1'b0;
    end
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
Controller that owns the game score and lives state and drives the digit bitmap renderer. It accepts point-add requests through a multi-cycle BCD adder FSM and keeps a frame-stable shadow copy of the score. Each pixel it works out which of three on-screen digit slots is active, and outputs that slot's digit code, in-slot offsets and an inside flag to the digit bitmap stage. It sits between the game-logic blocks and the number bitmap / VGA mux.

Parameters:
TOP_X, 16, left x of the hundreds-digit slot (pixels)
TOP_Y, 8, top y of all digit slots
DIGIT_W, 16, slot width; matches the 16-wide glyphs
DIGIT_H, 32, slot height; matches the 32-tall glyphs
DIGIT_GAP, 4, blank pixels between adjacent slots
LIVES_INIT, 3, lives value after reset or resetScore

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
pixelX  in  11  current VGA pixel x
pixelY  in  11  current VGA pixel y
startOfFrame  in  1  one-cycle pulse at the start of each frame
addReq  in  1  request to add addPoints to the score
addPoints  in  2x4  BCD points to add: [1]=tens, [0]=ones
loseLife  in  1  one-cycle pulse; decrement lives
resetScore  in  1  synchronous clear of score and lives
busy  out  1  adder FSM active; addReq is ignored while high
score  out  3x4  live BCD score: [2]=hundreds, [1]=tens, [0]=ones
digitCode  out  4  glyph index for the current pixel (0-9)
offsetX  out  11  x offset inside the active slot
offsetY  out  11  y offset inside the active slot
insideRectangle  out  1  pixel lies in a visible digit slot
lives  out  2  remaining lives
gameOver  out  1  high when lives==0

Behaviour:
- Reset values (asynchronous): score=0, shadow=0, busy=0, digitCode=0, offsetX=0, offsetY=0, insideRectangle=0, lives=LIVES_INIT, gameOver=0. FSM state is IDLE.
- Adder FSM states: IDLE, ADD0, ADD1, ADD2.
  - IDLE: when addReq=1, latch addPoints and go to ADD0; busy rises on the next cycle.
  - Any addPoints digit >9 is clamped to 9 at latch time.
  - ADD0: s = score[0] + pts[0]. If s>9, store s-10 and set carry=1; else store s and carry=0.
  - ADD1: same operation on score[1] + pts[1] + carry.
  - ADD2: s = score[2] + carry. If s>9 the score saturates to 999 (all three digits forced to 9). Return to IDLE.
  - busy=1 in ADD0, ADD1 and ADD2. An add completes in 3 cycles after acceptance.
  - addReq while busy is dropped, not queued.
- resetScore has highest priority:
  - Next cycle: score=0, lives=LIVES_INIT, FSM=IDLE, busy=0. Any in-flight add is aborted.
  - An addReq in the same cycle is ignored.
- loseLife: lives decrements by 1 and saturates at 0. gameOver is a registered flag equal to (lives==0). It works independently of the adder FSM.
- Shadow score: copied from score on startOfFrame only when the FSM is IDLE. If busy at startOfFrame, the shadow keeps its previous value until the next frame. This prevents mid-frame tearing.
- Slot geometry, for k=0 (hundreds), 1 (tens), 2 (ones):
  - slotX(k) = TOP_X + k*(DIGIT_W+DIGIT_GAP).
  - A pixel is in slot k when slotX(k) <= pixelX < slotX(k)+DIGIT_W and TOP_Y <= pixelY < TOP_Y+DIGIT_H.
- Pixel outputs are registered, with exactly 1 cycle latency from pixelX/pixelY.
  - In slot k: digitCode = shadow digit for k, offsetX = pixelX - slotX(k), offsetY = pixelY - TOP_Y, insideRectangle = 1.
  - Outside every slot, including gap pixels: insideRectangle=0 and offsets=0. digitCode holds its last value.
- Leading-zero blanking (uses shadow values):
  - Hundreds slot is blanked (insideRectangle=0) when shadow[2]==0.
  - Tens slot is blanked when shadow[2]==0 and shadow[1]==0.
  - Ones slot is never blanked.
- score output tracks the live register and updates each FSM step.
- Reset asserted mid-add clears all state immediately. No partial score survives.

Test Plan:
- Reset, then score=0, shadow=0; scan row y=TOP_Y+5 -> insideRectangle=1 only for x in [56,72) (ones slot) with offsetX=x-56, digitCode=0. Hundreds and tens slots are blanked. Outputs lag pixel inputs by 1 cycle.
- score=047, addReq with addPoints={0,5} -> busy high for 3 cycles, score=052. Shadow stays 047 until the next startOfFrame with FSM idle.
- score=995, add {1,9} -> score saturates to 999.
- addReq on the cycle after acceptance, while busy=1 -> request ignored and score reflects one add only. resetScore during ADD1 -> score=000, lives=3, busy=0 next cycle.
- Three loseLife pulses -> lives 2,1,0 and gameOver=1. A fourth pulse -> lives stays 0.
- Pixel in the gap x=32..35 and at y=TOP_Y+DIGIT_H -> insideRectangle=0, offsets=0. startOfFrame while busy -> shadow unchanged.
